// File: rtl/sweeper_pkg.sv
// Shared definitions for the auto decoder sweeper: FSM state encoding and
// width helpers used when sizing counters from parameters.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_width(input int div);
        return (clog2(div) < 1) ? 1 : clog2(div);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Enable-gated prescaler: counts 0..DIV-1 while en is high and produces a
// single-cycle tick on the terminal count; clears whenever en is low.
module tick_divider
    import sweeper_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || (count == CNT_LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = en && (count == CNT_LAST);

endmodule

// File: rtl/auto_decoder_sweeper.sv
// Sweeps a select code through every value at a prescaled rate and drives a
// registered one-hot decode; single-shot or continuous, counting up or down.
module auto_decoder_sweeper
    import sweeper_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int DIV   = 4
) (
    input  logic                   clkin,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   mode_cont,
    input  logic                   dir_down,
    output logic [SEL_W-1:0]       sel,
    output logic [(1<<SEL_W)-1:0]  onehot,
    output logic                   step_tick,
    output logic                   busy,
    output logic                   done
);

    localparam int OUT_W = 1 << SEL_W;
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(OUT_W - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic             cont_q, cont_n;
    logic             down_q, down_n;
    logic             done_n;
    logic             tick;
    logic [SEL_W-1:0] sel_last;

    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] code);
        logic [OUT_W-1:0] d;
        d       = '0;
        d[code] = 1'b1;
        return d;
    endfunction

    // A stop request clears the prescaler in the same cycle so it can never
    // produce a tick that competes with the abort.
    tick_divider #(
        .DIV (DIV)
    ) u_div (
        .clkin (clkin),
        .rst_n (rst_n),
        .en    ((state == RUN) && !stop),
        .tick  (tick)
    );

    assign sel_last = down_q ? '0 : SEL_MAX;

    always_comb begin
        state_n = state;
        sel_n   = sel;
        cont_n  = cont_q;
        down_n  = down_q;
        done_n  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    sel_n   = dir_down ? SEL_MAX : '0;
                    cont_n  = mode_cont;
                    down_n  = dir_down;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (!cont_q && (sel == sel_last)) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        // Natural SEL_W-bit wrap gives the modulo-OUT_W sweep.
                        sel_n = down_q ? (sel - SEL_W'(1)) : (sel + SEL_W'(1));
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // onehot is decoded from the next-state select so it tracks sel exactly.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            cont_q    <= 1'b0;
            down_q    <= 1'b0;
            onehot    <= '0;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            cont_q    <= cont_n;
            down_q    <= down_n;
            onehot    <= (state_n == RUN) ? decode(sel_n) : '0;
            step_tick <= tick;
            done      <= done_n;
        end
    end

    assign busy = (state == RUN);

endmodule
